// File: rtl/axi_wr_arb_pkg.sv
// Shared types and constants for the AXI3 write-channel arbiter: FSM states,
// payload widths and the bit offsets of the fields packed into each payload.
package axi_wr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam int AW_W = 45;  // {awid, awaddr, awlen, awsize, awburst}
  localparam int W_W  = 36;  // {wdata, wstrb}
  localparam int B_W  = 6;   // {bid, bresp}

  localparam int AWBURST_LSB = 0;
  localparam int AWSIZE_LSB  = 2;
  localparam int AWLEN_LSB   = 5;
  localparam int AWADDR_LSB  = 9;
  localparam int AWID_LSB    = 41;
  localparam int AWLEN_W     = 4;

  localparam int WSTRB_LSB = 0;
  localparam int WDATA_LSB = 4;

  localparam int BRESP_LSB = 0;
  localparam int BID_LSB   = 2;

endpackage

// File: rtl/axi_rr_arbiter.sv
// Round-robin grant selection: the search starts one past the last granted
// index and wraps, so every requester is served within NM grants.
module axi_rr_arbiter #(
  parameter int NM = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NM-1:0]         req,
  input  logic                  advance,
  output logic [$clog2(NM)-1:0] gnt,
  output logic                  gnt_valid
);

  localparam int GW = $clog2(NM);

  logic [GW-1:0] last_q;
  logic [GW-1:0] idx;
  logic          found;

  // Pointer resets to the highest index so master 0 is searched first.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!resetn) begin
      last_q <= GW'(NM - 1);
    end else if (advance) begin
      last_q <= gnt;
    end
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned and infers a latch.
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NM; i++) begin
      idx = GW'((int'(last_q) + i) % NM);
      if (!found && req[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  assign gnt_valid = |req;

endmodule

// File: rtl/axi_wr_arbiter.sv
// Arbitrates NM AXI3 write masters onto one slave, one transaction at a time.
// Optional AXI_WR_ARB_WLAST_CHK_EN: generate s_wlast from awlen, flag m_wlast errors.
module axi_wr_arbiter
  import axi_wr_arb_pkg::*;
#(
  parameter int NM = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NM-1:0]         m_awvalid,
  output logic [NM-1:0]         m_awready,
  input  logic [NM*AW_W-1:0]    m_awpayload,
  input  logic [NM-1:0]         m_wvalid,
  output logic [NM-1:0]         m_wready,
  input  logic [NM*W_W-1:0]     m_wpayload,
  input  logic [NM-1:0]         m_wlast,
  output logic [NM-1:0]         m_bvalid,
  input  logic [NM-1:0]         m_bready,
  output logic [B_W-1:0]        m_bpayload,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [AW_W-1:0]       s_awpayload,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  output logic [W_W-1:0]        s_wpayload,
  output logic                  s_wlast,
  input  logic                  s_bvalid,
  output logic                  s_bready,
  input  logic [B_W-1:0]        s_bpayload,
  output logic [$clog2(NM)-1:0] grant
`ifdef AXI_WR_ARB_WLAST_CHK_EN
  ,
  output logic                  wlast_err
`endif
);

  localparam int GW = $clog2(NM);

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   rr_gnt;
  logic            rr_valid;
  logic            aw_take;
  logic [AW_W-1:0] aw_q;

  axi_rr_arbiter #(.NM(NM)) u_rr (
    .clk       (clk),
    .resetn    (resetn),
    .req       (m_awvalid),
    .advance   (aw_take),
    .gnt       (rr_gnt),
    .gnt_valid (rr_valid)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      // NOTE: the AW holding register is cleared on reset so s_awpayload is
      // deterministic; wide datapath registers normally skip reset.
      aw_q    <= '0;
    end else begin
      state_q <= state_d;
      if (aw_take) begin
        grant_q <= rr_gnt;
        aw_q    <= m_awpayload[rr_gnt*AW_W +: AW_W];
      end
    end
  end

`ifdef AXI_WR_ARB_WLAST_CHK_EN
  logic [AWLEN_W-1:0] beat_cnt_q;
  logic               w_hs;
  logic               wlast_err_q;

  assign w_hs = (state_q == ST_DATA) && s_wvalid && s_wready;

  // Counter holds beats remaining after the current one; zero marks the last.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      beat_cnt_q  <= '0;
      wlast_err_q <= 1'b0;
    end else if (aw_take) begin
      beat_cnt_q <= m_awpayload[rr_gnt*AW_W + AWLEN_LSB +: AWLEN_W];
    end else if (w_hs) begin
      beat_cnt_q <= beat_cnt_q - 1'b1;
      if (m_wlast[grant_q] != (beat_cnt_q == '0)) begin
        wlast_err_q <= 1'b1;
      end
    end
  end

  assign s_wlast   = (beat_cnt_q == '0);
  assign wlast_err = wlast_err_q;
`else
  assign s_wlast = m_wlast[grant_q];
`endif

  always_comb begin
    state_d    = state_q;
    aw_take    = 1'b0;
    m_awready  = '0;
    m_wready   = '0;
    m_bvalid   = '0;
    s_awvalid  = 1'b0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    s_wpayload = m_wpayload[grant_q*W_W +: W_W];
    unique case (state_q)
      ST_IDLE: begin
        if (rr_valid) begin
          aw_take           = 1'b1;
          m_awready[rr_gnt] = 1'b1;
          state_d           = ST_ADDR;
        end
      end
      ST_ADDR: begin
        s_awvalid = 1'b1;
        if (s_awready) state_d = ST_DATA;
      end
      ST_DATA: begin
        s_wvalid          = m_wvalid[grant_q];
        m_wready[grant_q] = s_wready;
        if (m_wvalid[grant_q] && s_wready && s_wlast) state_d = ST_RESP;
      end
      ST_RESP: begin
        m_bvalid[grant_q] = s_bvalid;
        s_bready          = m_bready[grant_q];
        if (s_bvalid && m_bready[grant_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // While reset is held no handshake may complete on either side.
    if (!resetn) begin
      state_d   = ST_IDLE;
      aw_take   = 1'b0;
      m_awready = '0;
      m_wready  = '0;
      m_bvalid  = '0;
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
      s_bready  = 1'b0;
    end
  end

  assign s_awpayload = aw_q;
  assign m_bpayload  = s_bpayload;
  assign grant       = grant_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed self-checking bench for axi_wr_arbiter (NM=2); inputs change and
// outputs are checked just after the falling edge.
module tb_axi_wr_arbiter;

  localparam int NM = 2;

  logic          clk = 1'b0;
  logic          resetn;
  logic [1:0]    m_awvalid, m_awready;
  logic [89:0]   m_awpayload;
  logic [1:0]    m_wvalid, m_wready, m_wlast;
  logic [71:0]   m_wpayload;
  logic [1:0]    m_bvalid, m_bready;
  logic [5:0]    m_bpayload;
  logic          s_awvalid, s_awready;
  logic [44:0]   s_awpayload;
  logic          s_wvalid, s_wready, s_wlast;
  logic [35:0]   s_wpayload;
  logic          s_bvalid, s_bready;
  logic [5:0]    s_bpayload;
  logic [0:0]    grant;
`ifdef AXI_WR_ARB_WLAST_CHK_EN
  logic          wlast_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_wr_arbiter #(.NM(NM)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .m_awvalid   (m_awvalid),
    .m_awready   (m_awready),
    .m_awpayload (m_awpayload),
    .m_wvalid    (m_wvalid),
    .m_wready    (m_wready),
    .m_wpayload  (m_wpayload),
    .m_wlast     (m_wlast),
    .m_bvalid    (m_bvalid),
    .m_bready    (m_bready),
    .m_bpayload  (m_bpayload),
    .s_awvalid   (s_awvalid),
    .s_awready   (s_awready),
    .s_awpayload (s_awpayload),
    .s_wvalid    (s_wvalid),
    .s_wready    (s_wready),
    .s_wpayload  (s_wpayload),
    .s_wlast     (s_wlast),
    .s_bvalid    (s_bvalid),
    .s_bready    (s_bready),
    .s_bpayload  (s_bpayload),
    .grant       (grant)
`ifdef AXI_WR_ARB_WLAST_CHK_EN
    ,
    .wlast_err   (wlast_err)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [44:0] aw_pl(input logic [3:0] id, input logic [31:0] addr,
                                        input logic [3:0] len);
    return {id, addr, len, 3'b010, 2'b01};
  endfunction

  function automatic logic [35:0] w_pl(input int k, input int b);
    return {32'hD000_0000 + 32'(k * 256 + b), 4'hF};
  endfunction

  task automatic clear_inputs();
    m_awvalid   = '0;
    m_awpayload = '0;
    m_wvalid    = '0;
    m_wpayload  = '0;
    m_wlast     = '0;
    m_bready    = '0;
    s_awready   = 1'b0;
    s_wready    = 1'b0;
    s_bvalid    = 1'b0;
    s_bpayload  = '0;
  endtask

  task automatic check_all_idle(input string tag);
    check({tag, "_valid_ready"},
          {m_awready, m_wready, m_bvalid, s_awvalid, s_wvalid, s_bready}, 64'h0);
    check({tag, "_grant"}, grant, 64'h0);
    check({tag, "_awpayload"}, s_awpayload, 64'h0);
  endtask

  // One complete transaction starting in IDLE. awv: masters raising AW;
  // exp: expected winner; pre_w: masters presenting W beat 0 ahead of time;
  // stall: cycles s_awready is held low in ADDR.
  task automatic run_txn(input logic [1:0] awv, input int exp, input logic [3:0] id,
                         input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] pre_w, input int stall, input string tag);
    logic [1:0]  wm;
    logic [44:0] exp_aw;
    wm     = 2'(1 << exp);
    exp_aw = aw_pl(id + 4'(exp), addr + 32'(exp * 32'h1000), len);
    @(negedge clk);
    s_bvalid  = 1'b0;
    m_bready  = '0;
    s_awready = 1'b0;
    s_wready  = 1'b1;
    m_awvalid = awv;
    for (int k = 0; k < NM; k++) begin
      m_awpayload[k*45 +: 45] = aw_pl(id + 4'(k), addr + 32'(k * 32'h1000), len);
      if (pre_w[k]) m_wpayload[k*36 +: 36] = w_pl(k, 0);
    end
    m_wvalid = pre_w;
    m_wlast  = '0;
    #1 check({tag, "_awready"}, m_awready, wm);

    @(negedge clk);
    m_awvalid = awv & ~wm;
    s_awready = (stall == 0);
    #1;
    check({tag, "_s_awvalid"}, s_awvalid, 1);
    check({tag, "_s_awpayload"}, s_awpayload, exp_aw);
    check({tag, "_grant"}, grant, exp);
    check({tag, "_addr_rdy_quiet"}, {m_awready, m_wready}, 0);
    for (int i = 1; i <= stall; i++) begin
      @(negedge clk);
      s_awready = (i == stall);
      #1;
      check({tag, "_stall_awvalid"}, s_awvalid, 1);
      check({tag, "_stall_awpayload"}, s_awpayload, exp_aw);
    end

    for (int b = 0; b <= int'(len); b++) begin
      @(negedge clk);
      m_wvalid = pre_w | wm;
      m_wpayload[exp*36 +: 36] = w_pl(exp, b);
      m_wlast = (b == int'(len)) ? wm : 2'b00;
      #1;
      check({tag, "_s_wvalid"}, s_wvalid, 1);
      check({tag, "_s_wpayload"}, s_wpayload, w_pl(exp, b));
      check({tag, "_s_wlast"}, s_wlast, (b == int'(len)));
      check({tag, "_m_wready"}, m_wready, wm);
    end

    @(negedge clk);
    m_wvalid   = pre_w & ~wm;
    m_wlast    = '0;
    s_bvalid   = 1'b1;
    s_bpayload = {id + 4'(exp), 2'b00};
    m_bready   = 2'b11;
    #1;
    check({tag, "_m_bvalid"}, m_bvalid, wm);
    check({tag, "_s_bready"}, s_bready, 1);
    check({tag, "_m_bpayload"}, m_bpayload, {id + 4'(exp), 2'b00});
    check({tag, "_resp_awready"}, m_awready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    resetn    = 1'b0;
    m_awvalid = 2'b01;
    repeat (2) @(negedge clk);
    #1;
    check_all_idle("reset");
    check("reset_no_aw_handshake", m_awready, 0);
    @(negedge clk);
    clear_inputs();
    resetn = 1'b1;

    // Single master: awid=3, addr=0x100, four beats, bid=3 only to m0.
    run_txn(2'b01, 0, 4'd3, 32'h100, 4'd3, 2'b00, 0, "single");

    // Both request continuously from reset: m0, m1, m0, m1.
    @(negedge clk);
    clear_inputs();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    run_txn(2'b11, 0, 4'd1, 32'h2000, 4'd1, 2'b00, 0, "rr0");
    run_txn(2'b11, 1, 4'd2, 32'h3000, 4'd0, 2'b00, 0, "rr1");
    run_txn(2'b11, 0, 4'd4, 32'h4000, 4'd2, 2'b00, 0, "rr2");
    run_txn(2'b11, 1, 4'd6, 32'h5000, 4'd1, 2'b00, 0, "rr3");

    // m1 presents W before its AW while m0 owns the channel.
    run_txn(2'b01, 0, 4'd8, 32'h6000, 4'd1, 2'b10, 0, "early_w_m0");
    run_txn(2'b10, 1, 4'd8, 32'h6000, 4'd2, 2'b10, 0, "early_w_m1");

    // AW held off by the slave for five cycles.
    run_txn(2'b01, 0, 4'd9, 32'h7000, 4'd0, 2'b00, 5, "aw_stall");

    // Reset during DATA beat 2, then a fresh m1 transaction.
    @(negedge clk);
    clear_inputs();
    m_awvalid = 2'b01;
    m_awpayload[44:0] = aw_pl(4'd2, 32'h8000, 4'd3);
    #1 check("midrst_awready", m_awready, 2'b01);
    @(negedge clk);
    m_awvalid = '0;
    s_awready = 1'b1;
    s_wready  = 1'b1;
    @(negedge clk);
    m_wvalid = 2'b01;
    m_wpayload[35:0] = w_pl(0, 0);
    @(negedge clk);
    m_wpayload[35:0] = w_pl(0, 1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1 check_all_idle("midrst");
    run_txn(2'b10, 1, 4'd5, 32'h9000, 4'd1, 2'b00, 0, "after_rst");

`ifdef AXI_WR_ARB_WLAST_CHK_EN
    // awlen=1 with m_wlast wrongly on beat 1.
    @(negedge clk);
    clear_inputs();
    m_awvalid = 2'b01;
    m_awpayload[44:0] = aw_pl(4'd5, 32'h200, 4'd1);
    #1 check("chk_awready", m_awready, 2'b01);
    @(negedge clk);
    m_awvalid = '0;
    s_awready = 1'b1;
    s_wready  = 1'b1;
    @(negedge clk);
    m_wvalid = 2'b01;
    m_wlast  = 2'b01;
    m_wpayload[35:0] = w_pl(0, 0);
    #1;
    check("chk_beat1_wlast", s_wlast, 0);
    check("chk_beat1_err", wlast_err, 0);
    @(negedge clk);
    m_wlast = 2'b00;
    m_wpayload[35:0] = w_pl(0, 1);
    #1;
    check("chk_beat2_wlast", s_wlast, 1);
    check("chk_beat2_err", wlast_err, 1);
    @(negedge clk);
    m_wvalid   = '0;
    s_bvalid   = 1'b1;
    s_bpayload = {4'd5, 2'b00};
    m_bready   = 2'b01;
    #1 check("chk_bvalid", m_bvalid, 2'b01);
    @(negedge clk);
    clear_inputs();
    #1 check("chk_err_sticky", wlast_err, 1);
`endif

    @(negedge clk);
    clear_inputs();
    #1 check("final_idle", {m_awready, m_wready, m_bvalid, s_awvalid, s_wvalid}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_wr_arbiter.md
AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 Parameter NM, default 2, number of write masters sharing the AXI3 slave write channels (2..4).
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 resetn  in  1  synchronous, active-low reset.
REQ-004 m_awvalid  in  NM  per-master AW valid.
REQ-005 m_awready  out  NM  per-master AW ready.
REQ-006 m_awpayload  in  NM*45  per-master {awid[3:0],awaddr[31:0],awlen[3:0],awsize[2:0],awburst[1:0]}.
REQ-007 m_wvalid  in  NM  per-master W valid.
REQ-008 m_wready  out  NM  per-master W ready.
REQ-009 m_wpayload  in  NM*36  per-master {wdata[31:0],wstrb[3:0]}.
REQ-010 m_wlast  in  NM  per-master last beat.
REQ-011 m_bvalid  out  NM  per-master B valid.
REQ-012 m_bready  in  NM  per-master B ready.
REQ-013 m_bpayload  out  6  {bid,bresp}, broadcast to all masters.
REQ-014 s_awvalid / s_awready  out / in  1 / 1  slave AW handshake.
REQ-015 s_awpayload  out  45  slave AW fields, same packing as REQ-006.
REQ-016 s_wvalid / s_wready  out / in  1 / 1  slave W handshake.
REQ-017 s_wpayload / s_wlast  out  36 / 1  slave W data, strobe, last.
REQ-018 s_bvalid / s_bready  in / out  1 / 1  slave B handshake.
REQ-019 s_bpayload  in  6  slave {bid,bresp}.
REQ-020 grant  out  $clog2(NM)  index of master owning the current transaction.

Function
REQ-021 FSM states are IDLE, ADDR, DATA and RESP; one write transaction is outstanding at a time.
REQ-022 In IDLE with any m_awvalid high, the round-robin winner SHALL get m_awready=1 for that cycle, its payload and index are registered, and the FSM moves to ADDR.
REQ-023 Round-robin priority starts at the master after the last granted index and wraps NM-1 to 0.
REQ-024 In ADDR, s_awvalid=1 with the registered payload, held stable until s_awready; on handshake go to DATA. Latency from m_awvalid to s_awvalid is 1 cycle.
REQ-025 In DATA, s_wvalid, s_wpayload and s_wlast are combinationally muxed from the granted master, m_wready[grant]=s_wready, and all other m_wready=0.
REQ-026 A W handshake with s_wlast=1 moves DATA to RESP.
REQ-027 In RESP, m_bvalid[grant]=s_bvalid, s_bready=m_bready[grant], and m_bpayload=s_bpayload; a B handshake returns the FSM to IDLE.
REQ-028 Non-granted masters see m_awready=0, m_wready=0 and m_bvalid=0 at all times.
REQ-029 A W beat presented before its AW is granted is stalled and never dropped.
REQ-030 A master raising m_awvalid in the same cycle as a B handshake is not granted until the next IDLE cycle (one idle cycle minimum between transactions).

Reset
REQ-031 On resetn=0 at a clk edge: FSM=IDLE, grant=0, the RR pointer selects master 0 next, and all valid/ready outputs=0 the following cycle; payload registers clear to 0.
REQ-032 Reset asserted mid-transaction abandons it without completing any handshake.

Configuration
REQ-033 With AXI_WR_ARB_WLAST_CHK_EN defined: a 4-bit beat counter loaded from awlen drives s_wlast on beat awlen+1, and a sticky output wlast_err (1 bit, cleared only by reset) sets when m_wlast disagrees with the counter.
REQ-034 Without AXI_WR_ARB_WLAST_CHK_EN: s_wlast=m_wlast[grant], and no counter or wlast_err port exists.

Structure
REQ-035 Package axi_wr_arb_pkg holds the state enum, the payload widths (45, 36, 6) and the field-offset constants.
REQ-036 Round-robin grant logic lives in sub-module axi_rr_arbiter (req[NM], advance, gnt index).

Verification
REQ-037 Single master: m0 AW awid=3, addr=0x100, awlen=3 -> s_awvalid 1 cycle later, 4 W beats forwarded, bid=3 / bresp=0 returned only to m0.
REQ-038 m0 and m1 request together from reset -> order m0, m1, m0, m1 across 4 transactions.
REQ-039 m1 presents W before AW while m0 owns the channel -> m_wready[1]=0 until m1 is granted, and no beat is lost.
REQ-040 s_awready held 0 for 5 cycles -> s_awpayload is stable and s_awvalid stays high.
REQ-041 resetn=0 during DATA beat 2 -> next cycle all outputs are 0, grant=0, and a fresh m1 request is served normally.
REQ-042 With the macro: awlen=1 and m_wlast on beat 1 -> s_wlast on beat 2 and wlast_err=1.
